// File: rtl/spi_master_param_if.sv
// spi_master_param_if: request/response handshake and SPI pin
// bundle shared by spi_master_param and its host.
interface spi_master_param_if #(
  parameter int DATA_W = 16,
  parameter int NUM_SS = 2
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [SS_W-1:0]   ss_sel;
  logic              cpol;
  logic              cpha;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  start, data_in, ss_sel,
    input  cpol, cpha, miso,
    output sclk, mosi, ss_n,
    output busy, done, data_out
  );

  modport slave (
    output start, data_in, ss_sel,
    output cpol, cpha, miso,
    input  sclk, mosi, ss_n,
    input  busy, done, data_out
  );
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param: SPI master, modes 0-3, parameterised width/divider.
// Macro SPI_LSB_FIRST_EN switches both directions to LSB first.
module spi_master_param #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 2
) (
  input logic clk,
  input logic rst,
  spi_master_param_if.master bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_END = EW'(2 * DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     div_cnt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] dout_q;
  logic [NUM_SS-1:0] ss_q;
  logic [NUM_SS-1:0] ss_dec;
  logic              pha;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              accept;
  logic              toggle;
  logic              lead;
  logic              do_smp;
  logic              do_emit;
  logic              fin;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic head(input logic [DATA_W-1:0] v);
    return v[0];
  endfunction

  function automatic logic [DATA_W-1:0] rest(
    input logic [DATA_W-1:0] v
  );
    return v >> 1;
  endfunction

  assign rx_next = {bus.miso, rx_sr[DATA_W-1:1]};
`else
  function automatic logic head(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] rest(
    input logic [DATA_W-1:0] v
  );
    return v << 1;
  endfunction

  assign rx_next = {rx_sr[DATA_W-2:0], bus.miso};
`endif

  // edge_cnt is the index of the next sclk toggle; even = leading
  assign tick    = (div_cnt == DIV_LAST);
  assign accept  = (state == IDLE) && !done_q && bus.start;
  assign toggle  = tick && ((state == SETUP) ||
                   ((state == SHIFT) && (edge_cnt != EDGE_END)));
  assign lead    = ~edge_cnt[0];
  assign do_smp  = toggle && (lead != pha);
  assign do_emit = toggle && (lead == pha);
  assign fin     = (state == HOLD) && tick;

  // slave-select decode; out-of-range index selects nothing
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (32'(bus.ss_sel) == i) ss_dec[i] = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = SETUP;
      SETUP: if (tick) state_nx = SHIFT;
      SHIFT: if (tick && (edge_cnt == EDGE_END)) state_nx = HOLD;
      HOLD:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // half-period divider and sclk toggle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;
      if (accept)      edge_cnt <= '0;
      else if (toggle) edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // serial clock, slave selects and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= 1'b0;
      ss_q   <= '1;
      pha    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      busy_q <= accept | (busy_q & ~done_q);
      if (accept) begin
        sclk_q <= bus.cpol;
        ss_q   <= ss_dec;
        pha    <= bus.cpha;
      end else begin
        if (toggle) sclk_q <= ~sclk_q;
        if (fin)    ss_q   <= '1;
      end
    end
  end

  // transmit path: cpha=0 presents the first bit at capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr  <= '0;
      mosi_q <= 1'b0;
    end else if (accept) begin
      tx_sr  <= bus.cpha ? bus.data_in : rest(bus.data_in);
      mosi_q <= bus.cpha ? 1'b0 : head(bus.data_in);
    end else if (fin) begin
      mosi_q <= 1'b0;
    end else if (do_emit) begin
      tx_sr  <= rest(tx_sr);
      mosi_q <= head(tx_sr);
    end
  end

  // receive path and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sr  <= '0;
      dout_q <= '0;
    end else begin
      if (accept)      rx_sr <= '0;
      else if (do_smp) rx_sr <= rx_next;
      if (fin) dout_q <= rx_sr;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss_n     = ss_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: random and directed transfers against a
// word-level SPI slave model; honours SPI_LSB_FIRST_EN.
`timescale 1ns/1ps
module tb_spi_master_param;
  localparam int DW  = 16;
  localparam int DIV = 4;
  localparam int NSS = 2;
  localparam int SW  = 1;
  localparam int LAT = 1 + DIV * (2 * DW + 2);
  localparam int LAT3 = 1 + 1 * (2 * 8 + 2);

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lb = 1'b0;
  logic s_miso = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DW), .NUM_SS(NSS)) bus();
  spi_master_param_if #(.DATA_W(8), .NUM_SS(3)) bus3();

  spi_master_param #(
    .DATA_W(DW), .CLK_DIV(DIV), .NUM_SS(NSS)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  spi_master_param #(
    .DATA_W(8), .CLK_DIV(1), .NUM_SS(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  assign bus.miso  = lb ? bus.mosi : s_miso;
  assign bus3.miso = bus3.mosi;

  // wire position of the k-th bit on the line
  function automatic int bpos(input int k, input int w);
    return LSB ? k : w - 1 - k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [DW-1:0] d, input logic [DW-1:0] sw,
                      input logic pol, input logic pha,
                      input logic [SW-1:0] sel, input bit loop,
                      input bit dbl, input bit ones);
    logic [DW-1:0] exp_out, srx, dout;
    logic [NSS-1:0] exp_ss;
    logic prev, idle0, lead;
    int tog, sidx, rcnt, dones, lat, ss_bad, mosi_low;
    exp_out = loop ? d : sw;
    exp_ss = '1;
    exp_ss[sel] = 1'b0;
    srx = '0; dout = '0; idle0 = 1'b0; prev = 1'b0;
    tog = 0; sidx = 0; rcnt = 0; dones = 0;
    lat = -1; ss_bad = 0; mosi_low = 0;
    lb = loop;
    s_miso = 1'b0;
    if (!pha) begin
      s_miso = sw[bpos(0, DW)];
      sidx = 1;
    end
    bus.data_in = d; bus.cpol = pol; bus.cpha = pha;
    bus.ss_sel = sel; bus.start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < LAT + 8; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.start = 1'b0;
        idle0 = bus.sclk;
        prev = bus.sclk;
      end
      if (dbl && n == 20) begin
        bus.start = 1'b1; bus.data_in = ~d;
        bus.cpol = ~pol; bus.ss_sel = ~sel;
      end
      if (dbl && n == 21) bus.start = 1'b0;
      if (bus.sclk !== prev) begin
        tog++;
        lead = (tog % 2) == 1;
        if (lead != pha) begin
          if (rcnt < DW) srx[bpos(rcnt, DW)] = bus.mosi;
          rcnt++;
        end else begin
          if (sidx < DW) s_miso = sw[bpos(sidx, DW)];
          sidx++;
        end
      end
      prev = bus.sclk;
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = n + 1;
          dout = bus.data_out;
        end
      end else if (bus.busy) begin
        if (bus.ss_n !== exp_ss) ss_bad++;
        if (tog >= 1 && bus.mosi !== 1'b1) mosi_low++;
      end
    end
    chk("latency", lat, LAT);
    chk("done_count", dones, 1);
    chk("data_out", dout, exp_out);
    chk("data_out_hold", bus.data_out, exp_out);
    chk("slave_rx", srx, d);
    chk("sclk_toggles", tog, 2 * DW);
    chk("sclk_idle_start", idle0, pol);
    chk("sclk_idle_end", bus.sclk, pol);
    chk("ss_n_during", ss_bad, 0);
    chk("ss_n_after", bus.ss_n, {NSS{1'b1}});
    chk("mosi_idle", bus.mosi, 0);
    chk("busy_idle", bus.busy, 0);
    if (ones) chk("mosi_const_shift", mosi_low, 0);
  endtask

  task automatic abort_test(input logic [DW-1:0] d);
    int dones;
    lb = 1'b1;
    bus.data_in = d; bus.cpol = 1'b1; bus.cpha = 1'b0;
    bus.ss_sel = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_ss_n", bus.ss_n, {NSS{1'b1}});
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data_out", bus.data_out, 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst = 1'b1;
    repeat (LAT) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_sclk_idle", bus.sclk, 0);
  endtask

  task automatic b2b_test(input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2);
    int lat;
    logic [DW-1:0] dout;
    lb = 1'b1;
    lat = -1;
    dout = '0;
    bus.data_in = d1; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.ss_sel = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < LAT + 5 && !bus.done; n++) @(negedge clk);
    chk("b2b_first_done", bus.done, 1);
    @(negedge clk);
    bus.data_in = d2; bus.start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < LAT + 5 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
      end
      if (bus.done) begin
        lat = n + 1;
        dout = bus.data_out;
      end
    end
    chk("b2b_latency", lat, LAT);
    chk("b2b_data", dout, d2);
    @(negedge clk);
  endtask

  task automatic ss3_test(input logic [1:0] sel, input logic [7:0] d);
    logic [2:0] exp_ss;
    logic [7:0] dout;
    int bad, lat;
    exp_ss = 3'b111;
    if (sel < 2'd3) exp_ss[sel] = 1'b0;
    dout = '0; bad = 0; lat = -1;
    bus3.data_in = d; bus3.cpol = 1'b0; bus3.cpha = 1'b1;
    bus3.ss_sel = sel; bus3.start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) bus3.start = 1'b0;
      if (bus3.done) begin
        lat = n + 1;
        dout = bus3.data_out;
      end else if (bus3.busy && bus3.ss_n !== exp_ss) begin
        bad++;
      end
    end
    chk("ss3_latency", lat, LAT3);
    chk("ss3_ss_n", bad, 0);
    chk("ss3_data", dout, d);
    @(negedge clk);
    chk("ss3_ss_idle", bus3.ss_n, 3'b111);
  endtask

  initial begin
    bus.start = 1'b0; bus.data_in = '0; bus.ss_sel = '0;
    bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus3.start = 1'b0; bus3.data_in = '0; bus3.ss_sel = '0;
    bus3.cpol = 1'b0; bus3.cpha = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sclk", bus.sclk, 0);
    chk("reset_ss_n", bus.ss_n, {NSS{1'b1}});
    chk("reset_busy", bus.busy, 0);
    chk("reset_data_out", bus.data_out, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    xfer(16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    xfer(16'h23A2, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    xfer(16'hFFFF, 16'h3C5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    xfer(16'h6E19, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    xfer(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    abort_test(16'hBEEF);
    xfer(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    b2b_test(16'hC3E1, 16'h5A0F);

    for (int i = 0; i < 10; i++) begin
      xfer(DW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           SW'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b0);
    end

    ss3_test(2'd3, 8'h96);
    ss3_test(2'd2, 8'h3B);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
